// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter/sequencer for a single-port 16-bit RAM.
// The data port (D) has priority over instruction fetch (F). A starvation
// counter forces a fetch grant after STARVE_LIMIT consecutive data grants
// that were made while a fetch was pending.
// The RAM acts on the falling clock edge and has a registered read output.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no access in flight; grant window open
// S_ACCESS | latched request on the RAM bus for one cycle; no grants
// S_RESP   | owner's rvalid pulse with rsp_rdata; grant window open again
module mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] rsp_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_starve_cnt;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_we;
  logic            r_owner_d;   // 1 = data port owns the access in flight
  logic            w_win;
  logic            w_force_f;
  logic            w_grant;

  // Arbitration, grant outputs and next-state decode
  always_comb begin
    w_state_nxt = r_state;
    w_win       = 1'b0;
    w_force_f   = 1'b0;
    d_gnt       = 1'b0;
    f_gnt       = 1'b0;
    w_grant     = 1'b0;

    w_win     = ((r_state == S_IDLE) || (r_state == S_RESP)) && !rst;
    w_force_f = (r_starve_cnt == CW'(STARVE_LIMIT)) && f_req;

    if (w_win) begin
      if (d_req && !w_force_f) begin
        d_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
    end
    w_grant = d_gnt | f_gnt;

    case (r_state)
      S_IDLE:   w_state_nxt = w_grant ? S_ACCESS : S_IDLE;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = w_grant ? S_ACCESS : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Starvation counter: counts data grants made while a fetch waits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!f_req || f_gnt) begin
      r_starve_cnt <= '0;
    end else if (d_gnt && (r_starve_cnt != CW'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end

  // Capture the granted request; the RAM bus is driven from these registers
  // so a write already in its ACCESS cycle completes even if reset arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_owner_d <= 1'b0;
    end else if (d_gnt) begin
      r_addr    <= d_addr;
      r_wdata   <= d_wdata;
      r_we      <= d_we;
      r_owner_d <= 1'b1;
    end else if (f_gnt) begin
      r_addr    <= f_addr;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_owner_d <= 1'b0;
    end
  end

  // Response capture at the end of ACCESS; rvalid pulses for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
    end else if (r_state == S_ACCESS) begin
      rsp_rdata <= r_we ? '0 : ram_rdata;
      f_rvalid  <= !r_owner_d;
      d_rvalid  <= r_owner_d;
    end else begin
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
    end
  end

  assign ram_we    = (r_state == S_ACCESS) && r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign busy      = (r_state == S_ACCESS);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a falling-edge, registered-read RAM model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] rsp_rdata;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        busy;

  logic [15:0] mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .rsp_rdata (rsp_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write and registered read on the falling edge
  always @(negedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0] = 16'h80FE;
    ram_rdata = 16'h0000;

    rst = 1'b1; f_req = 1'b1; f_addr = 16'h0; d_req = 1'b1; d_we = 1'b0;
    d_addr = 16'h0; d_wdata = 16'h0;
    tick();
    check_eq("rst_f_gnt", {31'd0, f_gnt}, 32'd0);
    check_eq("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check_eq("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
    check_eq("rst_rsp", {16'd0, rsp_rdata}, 32'd0);
    check_eq("rst_rvalid", {30'd0, f_rvalid, d_rvalid}, 32'd0);
    f_req = 1'b0; d_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // single fetch
    f_req = 1'b1; f_addr = 16'h0000;
    #1;
    check_eq("fetch_gnt", {30'd0, f_gnt, d_gnt}, 32'h2);
    tick();
    f_req = 1'b0;
    #1;
    check_eq("fetch_busy", {31'd0, busy}, 32'd1);
    check_eq("fetch_ram_we", {31'd0, ram_we}, 32'd0);
    check_eq("fetch_ram_addr", {16'd0, ram_addr}, 32'd0);
    tick();
    check_eq("fetch_rvalid", {30'd0, f_rvalid, d_rvalid}, 32'h2);
    check_eq("fetch_rdata", {16'd0, rsp_rdata}, 32'h80FE);
    tick();
    check_eq("fetch_rvalid_off", {30'd0, f_rvalid, d_rvalid}, 32'h0);

    // store then load to address 7
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'd7; d_wdata = 16'hBEEF;
    #1;
    check_eq("st_gnt", {30'd0, f_gnt, d_gnt}, 32'h1);
    tick();
    d_req = 1'b0;
    #1;
    check_eq("st_ram_we", {31'd0, ram_we}, 32'd1);
    check_eq("st_ram_addr", {16'd0, ram_addr}, 32'd7);
    check_eq("st_ram_wdata", {16'd0, ram_wdata}, 32'hBEEF);
    tick();
    check_eq("st_ram_we_off", {31'd0, ram_we}, 32'd0);
    check_eq("st_rvalid", {30'd0, f_rvalid, d_rvalid}, 32'h1);
    check_eq("st_rdata", {16'd0, rsp_rdata}, 32'h0000);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'd7;
    #1;
    check_eq("ld_gnt_in_resp", {30'd0, f_gnt, d_gnt}, 32'h1);
    tick();
    d_req = 1'b0;
    #1;
    check_eq("ld_ram_we", {31'd0, ram_we}, 32'd0);
    tick();
    check_eq("ld_rvalid", {30'd0, f_rvalid, d_rvalid}, 32'h1);
    check_eq("ld_rdata", {16'd0, rsp_rdata}, 32'hBEEF);
    tick();

    // simultaneous requests: D first, F in the following RESP
    f_req = 1'b1; f_addr = 16'd0; d_req = 1'b1; d_we = 1'b0; d_addr = 16'd7;
    #1;
    check_eq("sim_first_gnt", {30'd0, f_gnt, d_gnt}, 32'h1);
    tick();
    d_req = 1'b0;
    #1;
    check_eq("sim_access_gnt", {30'd0, f_gnt, d_gnt}, 32'h0);
    tick();
    check_eq("sim_d_rvalid", {30'd0, f_rvalid, d_rvalid}, 32'h1);
    check_eq("sim_d_rdata", {16'd0, rsp_rdata}, 32'hBEEF);
    check_eq("sim_second_gnt", {30'd0, f_gnt, d_gnt}, 32'h2);
    tick();
    f_req = 1'b0;
    tick();
    check_eq("sim_f_rvalid", {30'd0, f_rvalid, d_rvalid}, 32'h2);
    check_eq("sim_f_rdata", {16'd0, rsp_rdata}, 32'h80FE);
    tick();

    // starvation: both held high, expect D,D,D,D,F,D,D,D,D,F
    begin
      logic [9:0] exp_f;
      exp_f = 10'b1000010000;   // bit i set where grant i is F
      f_req = 1'b1; f_addr = 16'd0; d_req = 1'b1; d_we = 1'b0; d_addr = 16'd7;
      for (int i = 0; i < 10; i++) begin
        #1;
        check_eq($sformatf("starve_gnt%0d", i), {30'd0, f_gnt, d_gnt},
                 exp_f[i] ? 32'h2 : 32'h1);
        check_eq($sformatf("starve_cnt%0d", i), {31'd0, (dut.r_starve_cnt <= 3'd4)}, 32'd1);
        tick();
        tick();
      end
      f_req = 1'b0; d_req = 1'b0;
      tick();
      tick();
    end

    // back-to-back loads from address 0
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("b2b_gnt%0d", i), {30'd0, f_gnt, d_gnt}, 32'h1);
      check_eq($sformatf("b2b_busy_lo%0d", i), {31'd0, busy}, 32'd0);
      check_eq($sformatf("b2b_rvalid%0d", i), {31'd0, d_rvalid}, (i > 0) ? 32'd1 : 32'd0);
      tick();
      if (i == 2) d_req = 1'b0;
      #1;
      check_eq($sformatf("b2b_busy_hi%0d", i), {31'd0, busy}, 32'd1);
      check_eq($sformatf("b2b_rvalid_off%0d", i), {31'd0, d_rvalid}, 32'd0);
      tick();
    end
    check_eq("b2b_last_rvalid", {31'd0, d_rvalid}, 32'd1);
    check_eq("b2b_last_rdata", {16'd0, rsp_rdata}, 32'h80FE);
    check_eq("b2b_no_gnt", {30'd0, f_gnt, d_gnt}, 32'h0);
    tick();
    check_eq("b2b_rvalid_end", {31'd0, d_rvalid}, 32'd0);

    // reset during the ACCESS cycle of a store to address 3
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'd3; d_wdata = 16'h1234;
    #1;
    check_eq("rma_gnt", {30'd0, f_gnt, d_gnt}, 32'h1);
    tick();
    d_req = 1'b0; rst = 1'b1;
    #1;
    check_eq("rma_ram_we", {31'd0, ram_we}, 32'd1);
    tick();
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    #1;
    check_eq("rma_gnt_in_rst", {30'd0, f_gnt, d_gnt}, 32'h0);
    check_eq("rma_rvalid", {30'd0, f_rvalid, d_rvalid}, 32'h0);
    check_eq("rma_ram_we_off", {31'd0, ram_we}, 32'd0);
    check_eq("rma_ram_addr", {16'd0, ram_addr}, 32'd0);
    check_eq("rma_busy", {31'd0, busy}, 32'd0);
    check_eq("rma_rsp", {16'd0, rsp_rdata}, 32'd0);
    check_eq("rma_mem3", {16'd0, mem[3]}, 32'h1234);
    f_req = 1'b0; d_req = 1'b0; rst = 1'b0;
    tick();
    check_eq("rma_no_rvalid", {30'd0, f_rvalid, d_rvalid}, 32'h0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'd3;
    #1;
    check_eq("rma_ld_gnt", {30'd0, f_gnt, d_gnt}, 32'h1);
    tick();
    d_req = 1'b0;
    tick();
    check_eq("rma_ld_rvalid", {31'd0, d_rvalid}, 32'd1);
    check_eq("rma_ld_rdata", {16'd0, rsp_rdata}, 32'h1234);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the processor's single-port 16-bit RAM. The RAM writes and reads on the falling clock edge and has a registered read output. The two requesters are instruction fetch (F) and load/store data (D). The block sits between the fetch/execute stages and the RAM. It grants one access at a time, drives the RAM address, write enable and write data for exactly one cycle, and returns read data with a one-cycle valid pulse. Data accesses have priority over fetches, and a consecutive-grant limit prevents fetch starvation.

Parameters:
AW, 16, address width (RAM address bus)
DW, 16, data width
STARVE_LIMIT, 4, max consecutive D grants while F is pending before F is forced (>=1)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous active-high reset
f_req  in  1  fetch request; held with f_addr until f_gnt
f_addr  in  AW  fetch address
f_gnt  out  1  fetch accepted this cycle (combinational)
f_rvalid  out  1  one-cycle pulse: rsp_rdata holds fetch result
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_gnt  out  1  data request accepted this cycle (combinational)
d_rvalid  out  1  one-cycle pulse: load data or store acknowledge
rsp_rdata  out  DW  registered response data (shared by F and D)
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM registered read data
busy  out  1  high in ACCESS state

Behaviour:
- States: IDLE, ACCESS, RESP. The grant window is open in IDLE and RESP only, and only when rst=0.
- Arbitration in the grant window:
  - If d_req=1 and F is not forced, d_gnt=1.
  - Else if f_req=1, f_gnt=1.
  - At most one gnt is high per cycle.
- F is forced when starve_cnt == STARVE_LIMIT and f_req=1.
- starve_cnt update on each grant:
  - Increments on a D grant while f_req=1 (saturates at STARVE_LIMIT).
  - Clears on an F grant.
  - Clears on any cycle with f_req=0.
- On a grant edge:
  - Latch addr, we (0 for F), wdata and owner into registers.
  - Next state is ACCESS.
  - With no grant, IDLE stays IDLE and RESP goes to IDLE.
- ACCESS (exactly 1 cycle):
  - ram_addr = latched addr; ram_wdata = latched wdata; ram_we = latched we.
  - The RAM acts at the falling edge inside this cycle.
  - On the next rising edge: rsp_rdata <= ram_rdata for a read, 16'h0000 for a write.
  - On the same edge, the owner's rvalid <= 1 and the state goes to RESP.
- RESP: the owner's rvalid=1 for this single cycle. A new grant may occur in the same cycle.
- Latency: gnt in cycle N, RAM access in N+1, rvalid and data in N+2.
- Peak throughput is one access per 2 cycles.
- ram_we=0 in every non-ACCESS cycle. ram_addr/ram_wdata hold their last latched values.
- Reset (rising edge with rst=1):
  - State goes to IDLE; starve_cnt=0.
  - rsp_rdata=0, f_rvalid=d_rvalid=0, latched addr/wdata/we=0.
  - Hence ram_we=0, ram_addr=0 and busy=0.
  - gnt outputs are 0 while rst=1.
- Reset mid-operation:
  - If rst rises during ACCESS, that cycle's RAM write still completes, because ram_we is driven from registers.
  - No rvalid is issued for the aborted access.
  - A pending RESP pulse is cleared.
- The requester must not change request fields while req=1 and gnt=0. It may drop or change req in the cycle after gnt.
- Address passes through unmodified (no wrap or bounds check); out-of-range handling belongs to the RAM.

Test Plan:
- Single fetch: RAM preloaded with 0x80FE at address 0. f_req=1, f_addr=0 in IDLE -> f_gnt=1 that cycle; ram_addr=0 and ram_we=0 next cycle; f_rvalid=1 with rsp_rdata=0x80FE two cycles after gnt.
- Store then load: d_we=1, d_addr=7, d_wdata=0xBEEF -> ram_we=1 for exactly one cycle; d_rvalid pulse with rsp_rdata=0x0000. Then a load of addr 7 -> d_rvalid with rsp_rdata=0xBEEF.
- Simultaneous: f_req=d_req=1 in IDLE -> d_gnt first, f_gnt in the following RESP cycle; f_rvalid arrives 2 cycles after d_rvalid.
- Starvation, STARVE_LIMIT=4, f_req and d_req held high continuously -> grant order D,D,D,D,F,D,D,D,D,F; starve_cnt never exceeds 4.
- Back-to-back: d_req held for 3 loads -> gnt every 2 cycles; d_rvalid pulses on alternate cycles; busy toggles 0/1.
- Reset mid-access: assert rst during the ACCESS cycle of a store to addr 3 = 0x1234 -> the RAM write completes (a later load returns 0x1234); no d_rvalid; all outputs 0 the cycle after reset; gnt=0 while rst=1.
